// File: rtl/mem_1w1r_pkg.sv
// mem_1w1r shared types.
// Read-data source selection for the registered output.
package mem_1w1r_pkg;

    typedef enum logic [1:0] {
        RD_HOLD,
        RD_MEM,
        RD_BYPASS,
        RD_CLEAR
    } rd_src_e;

    // Reset beats read; a same-address write wins over the array.
    function automatic rd_src_e rd_src(
        input logic rst,
        input logic read,
        input logic hit
    );
        if (rst)
            return RD_CLEAR;
        if (!read)
            return RD_HOLD;
        if (hit)
            return RD_BYPASS;
        return RD_MEM;
    endfunction

endpackage

// File: rtl/mem_1w1r.sv
// One-write one-read synchronous RAM.
// Registered read, hold when idle, write-first on collision.
module mem_1w1r #(
    parameter int ELEMENTS_W = 7,
    parameter int WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  read,
    input  logic [ELEMENTS_W-1:0] readaddress,
    output logic [WIDTH-1:0]      readdata,
    input  logic                  write,
    input  logic [ELEMENTS_W-1:0] writeaddress,
    input  logic [WIDTH-1:0]      writedata
);
    import mem_1w1r_pkg::*;

    localparam int DEPTH = 1 << ELEMENTS_W;

    logic [WIDTH-1:0] mem [0:DEPTH-1];
    logic             hit;
    rd_src_e          src;
    logic [WIDTH-1:0] rd_next;

    // Array write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (write)
            mem[writeaddress] <= writedata;
    end

    // Pick the next readdata value.
    always_comb begin
        rd_next = readdata;
        hit     = write && (readaddress == writeaddress);
        src     = rd_src(rst, read, hit);
        unique case (src)
            RD_CLEAR:  rd_next = '0;
            RD_BYPASS: rd_next = writedata;
            RD_MEM:    rd_next = mem[readaddress];
            RD_HOLD:   rd_next = readdata;
            default:   rd_next = readdata;
        endcase
    end

    // Output register; no combinational path to readdata.
    always_ff @(posedge clk) begin
        readdata <= rd_next;
    end

    // Enables must be known outside reset.
    a_enables_known: assert property (
        @(posedge clk) disable iff (rst)
        !$isunknown({read, write})
    );

endmodule

// File: tb/tb_mem_1w1r.sv
// Directed table-driven bench for mem_1w1r.
// Vectors carry inputs and the expected readdata after the edge.
module tb_mem_1w1r;

    logic        clk;
    logic        rst;
    logic        read;
    logic [6:0]  readaddress;
    logic [31:0] readdata;
    logic        write;
    logic [6:0]  writeaddress;
    logic [31:0] writedata;

    int total;
    int bad;

    typedef struct {
        logic        rst;
        logic        rd;
        logic [6:0]  ra;
        logic        wr;
        logic [6:0]  wa;
        logic [31:0] wd;
        logic [31:0] want;
        string       name;
    } vec_t;

    vec_t tab_a[$];
    vec_t tab_b[$];

    mem_1w1r #(
        .ELEMENTS_W(7),
        .WIDTH(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .read(read),
        .readaddress(readaddress),
        .readdata(readdata),
        .write(write),
        .writeaddress(writeaddress),
        .writedata(writedata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, want);
        end
    endtask

    task automatic drive(input logic r, input logic rd, input logic [6:0] ra,
                         input logic wr, input logic [6:0] wa,
                         input logic [31:0] wd);
        rst          = r;
        read         = rd;
        readaddress  = ra;
        write        = wr;
        writeaddress = wa;
        writedata    = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input vec_t v);
        drive(v.rst, v.rd, v.ra, v.wr, v.wa, v.wd);
        chk(v.name, readdata, v.want);
    endtask

    function automatic vec_t mk(input logic r, input logic rd,
                                input logic [6:0] ra, input logic wr,
                                input logic [6:0] wa, input logic [31:0] wd,
                                input logic [31:0] want, input string name);
        vec_t v;
        v.rst  = r;
        v.rd   = rd;
        v.ra   = ra;
        v.wr   = wr;
        v.wa   = wa;
        v.wd   = wd;
        v.want = want;
        v.name = name;
        return v;
    endfunction

    initial begin
        total = 0;
        bad   = 0;
        rst          = 1'b1;
        read         = 1'b1;
        readaddress  = '0;
        write        = 1'b0;
        writeaddress = '0;
        writedata    = '0;

        // reset, basic write/read
        tab_a.push_back(mk(1, 1, 0,   0, 0,   32'h0,        32'h0,        "rst0"));
        tab_a.push_back(mk(1, 1, 0,   0, 0,   32'h0,        32'h0,        "rst1"));
        tab_a.push_back(mk(0, 0, 0,   0, 0,   32'h0,        32'h0,        "rst_hold"));
        tab_a.push_back(mk(0, 0, 0,   1, 5,   32'hDEADBEEF, 32'h0,        "wr5"));
        tab_a.push_back(mk(0, 0, 0,   1, 127, 32'h12345678, 32'h0,        "wr127"));
        tab_a.push_back(mk(0, 1, 5,   0, 0,   32'h0,        32'hDEADBEEF, "rd5"));
        tab_a.push_back(mk(0, 1, 127, 0, 0,   32'h0,        32'h12345678, "rd127"));
        tab_a.push_back(mk(0, 1, 5,   0, 0,   32'h0,        32'hDEADBEEF, "rd5b"));

        // reread, collision, independent ports, reset+write
        tab_b.push_back(mk(0, 1, 5,   0, 0,   32'h0,        32'h0,        "reread5"));
        tab_b.push_back(mk(0, 0, 0,   1, 9,   32'h11111111, 32'h0,        "wr9"));
        tab_b.push_back(mk(0, 1, 9,   1, 9,   32'hAAAA5555, 32'hAAAA5555, "coll9"));
        tab_b.push_back(mk(0, 1, 9,   0, 0,   32'h0,        32'hAAAA5555, "rd9"));
        tab_b.push_back(mk(0, 0, 0,   1, 4,   32'h44,       32'hAAAA5555, "wr4"));
        tab_b.push_back(mk(0, 1, 4,   1, 3,   32'hCAFEF00D, 32'h44,       "indep"));
        tab_b.push_back(mk(0, 1, 3,   0, 0,   32'h0,        32'hCAFEF00D, "rd3"));
        tab_b.push_back(mk(1, 1, 6,   1, 6,   32'h66,       32'h0,        "rst_wr6"));
        tab_b.push_back(mk(0, 1, 6,   0, 0,   32'h0,        32'h66,       "rd6"));
        tab_b.push_back(mk(0, 0, 0,   1, 10,  32'hA5A5,     32'h66,       "wr10"));
        tab_b.push_back(mk(0, 1, 10,  0, 0,   32'h0,        32'hA5A5,     "rd10"));

        foreach (tab_a[i]) run(tab_a[i]);

        // hold for 10 idle cycles while overwriting the word just read
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 0, 1, 5, 32'h0);
            chk("hold", readdata, 32'hDEADBEEF);
        end

        foreach (tab_b[i]) run(tab_b[i]);

        // full sweep: fill, then back-to-back reads
        for (int i = 0; i < 128; i++)
            drive(0, 0, 0, 1, 7'(i), 32'(i) * 32'h01010101);
        for (int i = 0; i < 128; i++) begin
            drive(0, 1, 7'(i), 0, 0, 32'h0);
            chk("sweep", readdata, 32'(i) * 32'h01010101);
        end

        drive(0, 0, 0, 0, 0, 32'h0);
        chk("sweep_hold", readdata, 32'h7F7F7F7F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
